// File: rtl/wb_regfile_scoreboard.sv
// WB-stage commit into the RV32E register file, two bypassed read ports,
// a per-register pending-write scoreboard and a retired-instruction counter.
module wb_regfile_scoreboard #(
   parameter int NUM_REGS = 16,
   parameter int XLEN     = 32,
   parameter int PEND_W   = 2,
   parameter int CNT_W    = 64,
   localparam int AW      = $clog2(NUM_REGS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             invalid_WB,
   input  logic [AW-1:0]    rd_WB,
   input  logic [XLEN-1:0]  alu_result_WB,
   input  logic             regfile_we_WB,
   input  logic             stall,
   input  logic             flush,
   input  logic             issue_fire,
   input  logic             issue_we,
   input  logic [AW-1:0]    issue_rd,
   input  logic [AW-1:0]    rs1_addr,
   input  logic [AW-1:0]    rs2_addr,
   output logic [XLEN-1:0]  rs1_data,
   output logic [XLEN-1:0]  rs2_data,
   output logic             rs1_busy,
   output logic             rs2_busy,
   output logic             issue_rd_full,
   output logic [CNT_W-1:0] instret,
   output logic             sb_err
);

   localparam logic [PEND_W-1:0] PEND_MAX = '1;
   localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

   logic [NUM_REGS-1:0][XLEN-1:0]   regs;
   logic [NUM_REGS-1:0][PEND_W-1:0] pend;
   logic [NUM_REGS-1:0][PEND_W-1:0] pend_nxt;
   logic                            err_set;
   logic                            commit;
   logic                            wr_en;

   // A held (stalled) WB slot commits only on the cycle stall drops.
   assign commit = !invalid_WB && !stall;
   assign wr_en  = commit && regfile_we_WB;

   // Register file write; x0 is never written and stays at its reset value 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs <= '0;
      end else if (wr_en && rd_WB != '0) begin
         regs[rd_WB] <= alu_result_WB;
      end
   end

   // Next scoreboard state: flush wins, matched inc/dec cancel, saturate both ends.
   always_comb begin
      pend_nxt = pend;
      err_set  = 1'b0;
      for (int r = 1; r < NUM_REGS; r++) begin
         logic inc, dec;
         inc = issue_fire && issue_we && (issue_rd == AW'(r)) && !flush;
         dec = wr_en && (rd_WB == AW'(r));
         if (flush) begin
            pend_nxt[r] = '0;
         end else if (inc && !dec) begin
            if (pend[r] == PEND_MAX) err_set = 1'b1;
            else                     pend_nxt[r] = pend[r] + PEND_ONE;
         end else if (dec && !inc) begin
            // Commits of writes issued before a flush drain with pend already 0.
            if (pend[r] != '0) pend_nxt[r] = pend[r] - PEND_ONE;
         end
      end
      pend_nxt[0] = '0;
   end

   // Scoreboard, retire counter and sticky error state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend    <= '0;
         instret <= '0;
         sb_err  <= 1'b0;
      end else begin
         pend   <= pend_nxt;
         sb_err <= sb_err | err_set;
         if (commit) instret <= instret + CNT_W'(1);
      end
   end

   // Read ports with write-through bypass; the last pending write committing
   // this cycle is served by the bypass and so is not reported busy.
   always_comb begin
      rs1_data = '0;
      rs2_data = '0;
      rs1_busy = 1'b0;
      rs2_busy = 1'b0;
      if (rs1_addr != '0) begin
         rs1_data = (wr_en && rd_WB == rs1_addr) ? alu_result_WB : regs[rs1_addr];
         rs1_busy = (pend[rs1_addr] != '0) &&
                    !(wr_en && rd_WB == rs1_addr && pend[rs1_addr] == PEND_ONE);
      end
      if (rs2_addr != '0) begin
         rs2_data = (wr_en && rd_WB == rs2_addr) ? alu_result_WB : regs[rs2_addr];
         rs2_busy = (pend[rs2_addr] != '0) &&
                    !(wr_en && rd_WB == rs2_addr && pend[rs2_addr] == PEND_ONE);
      end
   end

   assign issue_rd_full = (issue_rd != '0) && (pend[issue_rd] == PEND_MAX);

endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// Randomized plus directed bench for wb_regfile_scoreboard, checked every cycle
// against an array/integer model of the register file and scoreboard.
module tb_wb_regfile_scoreboard;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        invalid_WB = 1'b1;
   logic [3:0]  rd_WB = '0;
   logic [31:0] alu_result_WB = '0;
   logic        regfile_we_WB = 1'b0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        issue_fire = 1'b0;
   logic        issue_we = 1'b0;
   logic [3:0]  issue_rd = '0;
   logic [3:0]  rs1_addr = '0;
   logic [3:0]  rs2_addr = '0;
   logic [31:0] rs1_data, rs2_data;
   logic        rs1_busy, rs2_busy, issue_rd_full, sb_err;
   logic [63:0] instret;

   int total = 0;
   int bad   = 0;

   wb_regfile_scoreboard dut (
      .clk(clk), .rst_n(rst_n), .invalid_WB(invalid_WB), .rd_WB(rd_WB),
      .alu_result_WB(alu_result_WB), .regfile_we_WB(regfile_we_WB), .stall(stall),
      .flush(flush), .issue_fire(issue_fire), .issue_we(issue_we), .issue_rd(issue_rd),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .issue_rd_full(issue_rd_full),
      .instret(instret), .sb_err(sb_err)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [31:0] m_reg [16];
   int          m_pend [16];
   logic [63:0] m_inst;
   logic        m_err;

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_reg[i]  = '0;
         m_pend[i] = 0;
      end
      m_inst = '0;
      m_err  = 1'b0;
   endtask

   // Model state advance from the inputs present at the clock edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         model_reset();
      end else begin
         bit commit, wr;
         int delta [16];
         commit = !invalid_WB && !stall;
         wr     = commit && regfile_we_WB;
         if (commit) m_inst = m_inst + 64'd1;
         if (wr && rd_WB != 0) m_reg[rd_WB] = alu_result_WB;
         if (flush) begin
            for (int i = 0; i < 16; i++) m_pend[i] = 0;
         end else begin
            for (int i = 0; i < 16; i++) delta[i] = 0;
            if (issue_fire && issue_we && issue_rd != 0) delta[issue_rd] += 1;
            if (wr && rd_WB != 0) delta[rd_WB] -= 1;
            for (int i = 1; i < 16; i++) begin
               if (delta[i] > 0 && m_pend[i] == 3) m_err = 1'b1;
               else if (m_pend[i] + delta[i] > 3) m_pend[i] = 3;
               else if (m_pend[i] + delta[i] < 0) m_pend[i] = 0;
               else m_pend[i] = m_pend[i] + delta[i];
            end
         end
      end
   end

   function automatic logic [31:0] exp_data(input logic [3:0] a);
      if (a == 0) return 32'd0;
      if (!invalid_WB && !stall && regfile_we_WB && rd_WB == a) return alu_result_WB;
      return m_reg[a];
   endfunction

   function automatic logic exp_busy(input logic [3:0] a);
      bool_t: begin end
      if (a == 0 || m_pend[a] == 0) return 1'b0;
      if (!invalid_WB && !stall && regfile_we_WB && rd_WB == a && m_pend[a] == 1) return 1'b0;
      return 1'b1;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      check("rs1_data", 64'(rs1_data), 64'(exp_data(rs1_addr)));
      check("rs2_data", 64'(rs2_data), 64'(exp_data(rs2_addr)));
      check("rs1_busy", 64'(rs1_busy), 64'(exp_busy(rs1_addr)));
      check("rs2_busy", 64'(rs2_busy), 64'(exp_busy(rs2_addr)));
      check("issue_rd_full", 64'(issue_rd_full),
            64'(issue_rd != 0 && m_pend[issue_rd] == 3));
      check("instret", instret, m_inst);
      check("sb_err", 64'(sb_err), 64'(m_err));
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wb_idle();
      invalid_WB = 1'b1; regfile_we_WB = 1'b0; stall = 1'b0;
      rd_WB = '0; alu_result_WB = '0;
   endtask

   task automatic wb_set(input logic [3:0] rd, input logic [31:0] d, input logic we);
      invalid_WB = 1'b0; regfile_we_WB = we; rd_WB = rd; alu_result_WB = d;
   endtask

   task automatic issue(input logic [3:0] rd);
      issue_fire = 1'b1; issue_we = 1'b1; issue_rd = rd;
   endtask

   task automatic issue_idle();
      issue_fire = 1'b0; issue_we = 1'b0;
   endtask

   initial begin
      model_reset();
      rs1_addr = 4'd5;
      #2;
      check("reset rs1_data", 64'(rs1_data), 64'd0);
      check("reset instret", instret, 64'd0);
      check("reset sb_err", 64'(sb_err), 64'd0);
      check("reset busy", 64'(rs1_busy), 64'd0);
      step();
      step();
      rst_n = 1'b1;
      step();

      // 1: plain commit
      wb_set(4'd5, 32'hDEADBEEF, 1'b1);
      step(); wb_idle();
      rs1_addr = 4'd5; #1;
      check("t1 rs1_data", 64'(rs1_data), 64'hDEADBEEF);
      check("t1 instret", instret, 64'd1);

      // 2: x0 write dropped but retired; bubble does nothing
      wb_set(4'd0, 32'h1234, 1'b1);
      step(); wb_idle();
      rs1_addr = 4'd0; #1;
      check("t2 x0", 64'(rs1_data), 64'd0);
      check("t2 instret", instret, 64'd2);
      wb_set(4'd5, 32'h0, 1'b1); invalid_WB = 1'b1;
      step(); wb_idle();
      rs1_addr = 4'd5; #1;
      check("t2 bubble data", 64'(rs1_data), 64'hDEADBEEF);
      check("t2 bubble instret", instret, 64'd2);

      // 3: stalled commit retires exactly once
      wb_set(4'd3, 32'd7, 1'b1); stall = 1'b1; rs1_addr = 4'd3;
      for (int i = 0; i < 4; i++) begin
         step();
         check("t3 stall data", 64'(rs1_data), 64'd0);
         check("t3 stall instret", instret, 64'd2);
      end
      stall = 1'b0;
      step(); wb_idle(); #1;
      check("t3 instret", instret, 64'd3);
      check("t3 data", 64'(rs1_data), 64'd7);

      // 4: hazard then same-cycle bypass
      issue(4'd7); step(); issue_idle();
      rs2_addr = 4'd7; #1;
      check("t4 busy", 64'(rs2_busy), 64'd1);
      wb_set(4'd7, 32'h55, 1'b1); #1;
      check("t4 bypass busy", 64'(rs2_busy), 64'd0);
      check("t4 bypass data", 64'(rs2_data), 64'h55);
      step(); wb_idle();

      // 5: two in flight, then saturation
      issue(4'd9); step(); step(); issue_idle();
      rs1_addr = 4'd9;
      wb_set(4'd9, 32'h99, 1'b1); #1;
      check("t5 busy two", 64'(rs1_busy), 64'd1);
      step(); wb_idle(); #1;
      check("t5 busy one", 64'(rs1_busy), 64'd1);
      wb_set(4'd9, 32'h9A, 1'b1); #1;
      check("t5 busy last", 64'(rs1_busy), 64'd0);
      step(); wb_idle(); #1;
      check("t5 busy none", 64'(rs1_busy), 64'd0);
      issue(4'd9); step(); step(); step(); issue_idle(); #1;
      check("t5 full", 64'(issue_rd_full), 64'd1);
      check("t5 no err", 64'(sb_err), 64'd0);
      issue(4'd9); step(); issue_idle(); #1;
      check("t5 err", 64'(sb_err), 64'd1);

      // 6: flush, drain write, async reset
      issue(4'd4); step(); issue(4'd6); step(); issue_idle();
      flush = 1'b1; step(); flush = 1'b0;
      rs1_addr = 4'd4; rs2_addr = 4'd6; #1;
      check("t6 busy4", 64'(rs1_busy), 64'd0);
      check("t6 busy6", 64'(rs2_busy), 64'd0);
      wb_set(4'd4, 32'hA5, 1'b1); step(); wb_idle(); #1;
      check("t6 drain data", 64'(rs1_data), 64'hA5);
      check("t6 drain busy", 64'(rs1_busy), 64'd0);
      rs1_addr = 4'd5; rst_n = 1'b0; #1;
      check("t6 rst data", 64'(rs1_data), 64'd0);
      check("t6 rst instret", instret, 64'd0);
      check("t6 rst err", 64'(sb_err), 64'd0);
      step(); rst_n = 1'b1;

      // randomized phase, checked by the per-cycle model compare
      for (int c = 0; c < 4000; c++) begin
         step();
         rst_n         = ($urandom_range(0, 799) != 0);
         invalid_WB    = ($urandom_range(0, 3) == 0);
         rd_WB         = 4'($urandom_range(0, 15));
         alu_result_WB = $urandom;
         regfile_we_WB = ($urandom_range(0, 3) != 0);
         stall         = ($urandom_range(0, 3) == 0);
         flush         = ($urandom_range(0, 49) == 0);
         issue_fire    = ($urandom_range(0, 1) == 1);
         issue_we      = ($urandom_range(0, 3) != 0);
         issue_rd      = 4'($urandom_range(0, 15));
         if (m_pend[issue_rd] == 3 && $urandom_range(0, 7) != 0) issue_fire = 1'b0;
         rs1_addr      = ($urandom_range(0, 1) == 1) ? rd_WB : 4'($urandom_range(0, 15));
         rs2_addr      = ($urandom_range(0, 1) == 1) ? issue_rd : 4'($urandom_range(0, 15));
      end
      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
